// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
//   state_t          : assembly FSM states (IDLE, SHIFT)
//   LSB_FIRST_ORDER  : MSB_FIRST encoding, first received bit -> data_out[0]
//   MSB_FIRST_ORDER  : MSB_FIRST encoding, first received bit -> data_out[WIDTH-1]
//   count_width()    : bit-count register width, $clog2(WIDTH+1)
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit LSB_FIRST_ORDER = 1'b0;
    localparam bit MSB_FIRST_ORDER = 1'b1;

    // The counter has to hold the value WIDTH itself, hence WIDTH+1.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_deser_bit_counter.sv
// Bit counter for the deserializer.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   clr       : synchronous clear to 0
//   load_one  : load 1 (first bit of a word accepted)
//   inc       : increment by one (another bit accepted)
//   count     : number of bits accepted for the current word
//   tc        : terminal count, high when the next increment reaches WIDTH
//               (the bit being accepted now completes the word)
module bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load_one,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load_one) begin
            count <= CW'(1);
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    // Decoded from the registered count only, so the top's next-state logic
    // can qualify it with its own increment without a combinational loop.
    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer.
// Assembles a framed serial bit stream into WIDTH-bit words.
//   clk, rst     : clock, synchronous active-high reset
//   serial_in    : serial data bit, sampled when in_valid=1
//   in_valid     : one bit accepted per cycle with in_valid=1
//   frame_start  : marks the accepted bit as bit 0 of a new word
//   data_out     : assembled word, stable while out_valid=1
//   out_valid    : data_out holds an unconsumed word
//   out_ready    : consumer accepts data_out when out_valid && out_ready
//   busy         : a word is partially assembled (state SHIFT)
//   frame_err    : one-cycle pulse, a partial word was discarded by frame_start
//   overrun      : sticky, a completed word was dropped (output full)
//   ovr_clr      : clears overrun (a simultaneous set wins)
//
// Handshake: a word transfers on every cycle where out_valid && out_ready.
// data_out/out_valid never change while out_valid=1 && out_ready=0, except
// through reset. A word completing in the same cycle as a transfer replaces
// the consumed one and out_valid stays high.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = LSB_FIRST_ORDER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             load_one;
    logic             inc;
    logic             complete;
    logic             ferr_next;
    logic [CW-1:0]    count;
    logic             tc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] asm_next;
    int               bit_k;
    int               bit_pos;

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load_one (load_one),
        .inc      (inc),
        .count    (count),
        .tc       (tc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        state_next = state;
        load_one   = 1'b0;
        inc        = 1'b0;
        complete   = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                // Bits without frame_start are not part of any word here.
                if (in_valid && frame_start) begin
                    load_one   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (in_valid) begin
                    if (frame_start) begin
                        // Restart on the new bit; the partial word is lost.
                        load_one  = 1'b1;
                        ferr_next = 1'b1;
                    end else begin
                        inc = 1'b1;
                        if (tc) begin
                            complete   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word as it looks with the current bit placed. A load starts from zero
    // so no bits of an abandoned word survive into the new one.
    always_comb begin
        bit_k    = load_one ? 0 : int'(count);
        bit_pos  = (MSB_FIRST == MSB_FIRST_ORDER) ? (WIDTH - 1 - bit_k) : bit_k;
        asm_next = load_one ? '0 : shreg;
        for (int i = 0; i < WIDTH; i++) begin
            if ((load_one || inc) && (i == bit_pos)) begin
                asm_next[i] = serial_in;
            end
        end
    end

    // Assembly shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load_one || inc) begin
            shreg <= asm_next;
        end
    end

    // Output register and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_next;
            if (complete) begin
                if (!out_valid || out_ready) begin
                    data_out  <= asm_next;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A drop in this cycle takes priority over the clear.
            if (ovr_clr && !(complete && out_valid && !out_ready)) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         serial_in;
    logic         in_valid;
    logic         frame_start;
    logic         out_ready;
    logic         ovr_clr;
    logic [W-1:0] data_out_l;
    logic         out_valid_l;
    logic         busy_l;
    logic         frame_err_l;
    logic         overrun_l;
    logic [W-1:0] data_out_m;
    logic         out_valid_m;
    logic         busy_m;
    logic         frame_err_m;
    logic         overrun_m;

    int vectors;
    int miscompares;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs (LSB-first and MSB-first) ----------------
    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .data_out    (data_out_l),
        .out_valid   (out_valid_l),
        .out_ready   (out_ready),
        .busy        (busy_l),
        .frame_err   (frame_err_l),
        .overrun     (overrun_l),
        .ovr_clr     (ovr_clr)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .data_out    (data_out_m),
        .out_valid   (out_valid_m),
        .out_ready   (out_ready),
        .busy        (busy_m),
        .frame_err   (frame_err_m),
        .overrun     (overrun_m),
        .ovr_clr     (ovr_clr)
    );

    // ---------------- reference model ----------------
    // Received bits of the word in progress, in arrival order. A non-empty
    // list means a frame is open.
    logic         part[$];
    logic [W-1:0] m_dout_l;
    logic [W-1:0] m_dout_m;
    logic         m_ov;
    logic         m_ovr;
    logic         m_ferr;

    task automatic model_step(input logic r, s, iv, fs, rdy, clr);
        logic         done;
        logic         drop;
        logic [W-1:0] wl;
        logic [W-1:0] wm;
        done = 1'b0;
        drop = 1'b0;
        wl   = '0;
        wm   = '0;
        if (r) begin
            part.delete();
            m_dout_l = '0;
            m_dout_m = '0;
            m_ov     = 1'b0;
            m_ovr    = 1'b0;
            m_ferr   = 1'b0;
        end else begin
            m_ferr = 1'b0;
            if (iv) begin
                if (fs) begin
                    if (part.size() > 0) m_ferr = 1'b1;
                    part.delete();
                    part.push_back(s);
                end else if (part.size() > 0) begin
                    part.push_back(s);
                    if (part.size() == W) begin
                        for (int k = 0; k < W; k++) begin
                            wl[k]         = part[k];
                            wm[W - 1 - k] = part[k];
                        end
                        done = 1'b1;
                        part.delete();
                    end
                end
            end
            if (done) begin
                if (!m_ov || rdy) begin
                    m_dout_l = wl;
                    m_dout_m = wm;
                    m_ov     = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (m_ov && rdy) begin
                m_ov = 1'b0;
            end
            if (drop) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, s, iv, fs, rdy, clr);
        rst         = r;
        serial_in   = s;
        in_valid    = iv;
        frame_start = fs;
        out_ready   = rdy;
        ovr_clr     = clr;
        model_step(r, s, iv, fs, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic         rst, sin, iv, fs, rdy, clr;
        logic [W-1:0] dout, doutm;
        logic         ov, busy, ferr, ovr;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic r, s, i, f, y, c,
                                input logic [W-1:0] d, dm,
                                input logic o, b, fe, ovr);
        vec_t v;
        v.rst = r; v.sin = s; v.iv = i; v.fs = f; v.rdy = y; v.clr = c;
        v.dout = d; v.doutm = dm; v.ov = o; v.busy = b; v.ferr = fe; v.ovr = ovr;
        return v;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; serial_in = 1'b0; in_valid = 1'b0;
        frame_start = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
        m_dout_l = '0; m_dout_m = '0; m_ov = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;

        //            rst s iv fs rdy clr  dout   doutm  ov busy ferr ovr
        // reset
        tab.push_back(mk(1,0,0,0,0,0, 4'h0, 4'h0, 0,0,0,0));
        // bits 1,0,1,1 -> 1101 (LSB-first) / 1011 (MSB-first), ready high
        tab.push_back(mk(0,1,1,1,1,0, 4'h0, 4'h0, 0,1,0,0));
        tab.push_back(mk(0,0,1,0,1,0, 4'h0, 4'h0, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,1,0, 4'h0, 4'h0, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,1,0, 4'hD, 4'hB, 1,0,0,0));
        tab.push_back(mk(0,0,0,0,1,0, 4'hD, 4'hB, 0,0,0,0));
        // 4'hA then 4'h5 back to back, ready low -> second dropped, overrun
        tab.push_back(mk(0,0,1,1,0,0, 4'hD, 4'hB, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'hD, 4'hB, 0,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'hD, 4'hB, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'hA, 4'h5, 1,0,0,0));
        tab.push_back(mk(0,1,1,1,0,0, 4'hA, 4'h5, 1,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'hA, 4'h5, 1,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'hA, 4'h5, 1,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'hA, 4'h5, 1,0,0,1));
        tab.push_back(mk(0,0,0,0,0,1, 4'hA, 4'h5, 1,0,0,0));
        // consume, then 4'hA pending; 4'h5 completes with ready -> replaced
        tab.push_back(mk(0,0,1,1,1,0, 4'hA, 4'h5, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'hA, 4'h5, 0,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'hA, 4'h5, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'hA, 4'h5, 1,0,0,0));
        tab.push_back(mk(0,1,1,1,0,0, 4'hA, 4'h5, 1,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'hA, 4'h5, 1,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'hA, 4'h5, 1,1,0,0));
        tab.push_back(mk(0,0,1,0,1,0, 4'h5, 4'hA, 1,0,0,0));
        tab.push_back(mk(0,0,0,0,1,0, 4'h5, 4'hA, 0,0,0,0));
        // frame_start after 2 bits -> frame_err pulse, then word 4'h8
        tab.push_back(mk(0,1,1,1,1,0, 4'h5, 4'hA, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,1,0, 4'h5, 4'hA, 0,1,0,0));
        tab.push_back(mk(0,0,1,1,1,0, 4'h5, 4'hA, 0,1,1,0));
        tab.push_back(mk(0,0,1,0,1,0, 4'h5, 4'hA, 0,1,0,0));
        tab.push_back(mk(0,0,1,0,1,0, 4'h5, 4'hA, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,1,0, 4'h8, 4'h1, 1,0,0,0));
        // word pending, 3 bits, reset, stray bit, then word 4'h3
        tab.push_back(mk(0,0,0,0,0,0, 4'h8, 4'h1, 1,0,0,0));
        tab.push_back(mk(0,1,1,1,0,0, 4'h8, 4'h1, 1,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'h8, 4'h1, 1,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'h8, 4'h1, 1,1,0,0));
        tab.push_back(mk(1,1,1,0,0,0, 4'h0, 4'h0, 0,0,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'h0, 4'h0, 0,0,0,0));
        tab.push_back(mk(0,1,1,1,0,0, 4'h0, 4'h0, 0,1,0,0));
        tab.push_back(mk(0,1,1,0,0,0, 4'h0, 4'h0, 0,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'h0, 4'h0, 0,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'h3, 4'hC, 1,0,0,0));
        // drop and clear in the same cycle -> overrun stays set
        tab.push_back(mk(0,1,1,1,0,0, 4'h3, 4'hC, 1,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'h3, 4'hC, 1,1,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 4'h3, 4'hC, 1,1,0,0));
        tab.push_back(mk(0,0,1,0,0,1, 4'h3, 4'hC, 1,0,0,1));
        tab.push_back(mk(0,0,0,0,0,1, 4'h3, 4'hC, 1,0,0,0));

        @(negedge clk);
        for (int n = 0; n < tab.size(); n++) begin
            drive(tab[n].rst, tab[n].sin, tab[n].iv, tab[n].fs, tab[n].rdy, tab[n].clr);
            check($sformatf("dir%0d data_out_lsb", n), 32'(data_out_l), 32'(tab[n].dout));
            check($sformatf("dir%0d data_out_msb", n), 32'(data_out_m), 32'(tab[n].doutm));
            check($sformatf("dir%0d out_valid", n), 32'(out_valid_l), 32'(tab[n].ov));
            check($sformatf("dir%0d busy", n), 32'(busy_l), 32'(tab[n].busy));
            check($sformatf("dir%0d frame_err", n), 32'(frame_err_l), 32'(tab[n].ferr));
            check($sformatf("dir%0d overrun", n), 32'(overrun_l), 32'(tab[n].ovr));
            check($sformatf("dir%0d out_valid_msb", n), 32'(out_valid_m), 32'(tab[n].ov));
            check($sformatf("dir%0d busy_msb", n), 32'(busy_m), 32'(tab[n].busy));
            check($sformatf("dir%0d frame_err_msb", n), 32'(frame_err_m), 32'(tab[n].ferr));
            check($sformatf("dir%0d overrun_msb", n), 32'(overrun_m), 32'(tab[n].ovr));
        end

        // ---------------- randomized phase against the model ----------------
        for (int n = 0; n < 3000; n++) begin
            logic r, s, iv, fs, rdy, clr;
            r   = ($urandom_range(0, 199) == 0);
            s   = 1'($urandom_range(0, 1));
            iv  = ($urandom_range(0, 3) != 0);
            fs  = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 19) == 0);
            drive(r, s, iv, fs, rdy, clr);
            check("rnd data_out_lsb", 32'(data_out_l), 32'(m_dout_l));
            check("rnd data_out_msb", 32'(data_out_m), 32'(m_dout_m));
            check("rnd out_valid", 32'(out_valid_l), 32'(m_ov));
            check("rnd busy", 32'(busy_l), 32'(part.size() > 0));
            check("rnd frame_err", 32'(frame_err_l), 32'(m_ferr));
            check("rnd overrun", 32'(overrun_l), 32'(m_ovr));
            check("rnd out_valid_msb", 32'(out_valid_m), 32'(m_ov));
            check("rnd overrun_msb", 32'(overrun_m), 32'(m_ovr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
